note_encoder: RTL
=================

NOTE_ENCODER -- requirements
Module: note_encoder

Interface
REQ-001 Parameter TICK_DIV, default 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); legal range 2 or greater.
REQ-002 Parameter DEB_CNT, default 4, consecutive sample ticks needed to accept a key change; legal range 1 to 15.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low; the only reset in the block.
REQ-005 keys  input  16  raw key switches, active-high, asynchronous to clk; keys[0] is note 0.
REQ-006 cn  output  5  current note code, 0..15 when a note plays, 5'd16 when idle; feeds the downstream note decoder directly.
REQ-007 note_valid  output  1  high while a note plays.
REQ-008 note_on  output  1  one-cycle pulse when cn takes a new note value (attack or retrigger).
REQ-009 note_off  output  1  one-cycle pulse when playing ends.

Function
REQ-010 Each keys bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-011 Tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick during the cycle its count equals TICK_DIV-1.
REQ-012 Debounce, per key: on each tick, synced != stable[i] increments cnt[i]; synced == stable[i] clears cnt[i].
REQ-013 Debounce: when cnt[i] reaches DEB_CNT, stable[i] SHALL toggle and cnt[i] SHALL clear, all in the same tick.
REQ-014 A rising edge of stable[i] is a press event; a falling edge is a release event. Events only occur on tick cycles.
REQ-015 FSM states: IDLE and PLAYING.
REQ-016 IDLE + press events: go to PLAYING; cn = lowest-index pressed key; note_valid=1; note_on=1 for one cycle.
REQ-017 PLAYING + press events: last-note priority; cn = lowest-index newly pressed key; note_on=1; note_valid stays 1; no note_off.
REQ-018 PLAYING + release of the current note, other stable keys still held: cn = lowest-index held key; note_on=1; no note_off; stay PLAYING.
REQ-019 PLAYING + release of the current note, no stable key held: go to IDLE; note_valid=0; note_off=1; cn=5'd16 (see REQ-027).
REQ-020 Release of a key that is not the current note SHALL change no output.
REQ-021 Release of the current note and a press in the same tick SHALL be handled as REQ-017: the press wins and there is no note_off.
REQ-022 All outputs SHALL be registered and update one clk after the tick that changed stable.
REQ-023 Latency, clean press to note_on: 2 sync cycles + DEB_CNT ticks + 1 cycle, with up to TICK_DIV cycles of tick-phase jitter.
REQ-024 note_on and note_off SHALL never be high in the same cycle; both are low in every non-tick-derived cycle.

Reset
REQ-025 While resetn=0, asynchronously: cn=5'd16, note_valid=0, note_on=0, note_off=0, state=IDLE, and all sync flops, stable, cnt and tick counter = 0.
REQ-026 Reset asserted mid-note SHALL abort it with no note_off pulse; after release, keys still held re-debounce from zero and produce a fresh note_on.

Configuration
REQ-027 Macro NOTE_ENCODER_HOLD_EN: when defined, entering IDLE SHALL keep cn at the last note value; note_valid=0 and note_off=1 still apply, and reset still forces 5'd16. When undefined, cn=5'd16 in IDLE per REQ-019.

Verification (bench uses TICK_DIV=4, DEB_CNT=3)
REQ-028 Reset, then hold keys=0 for 100 cycles -> cn=16, note_valid=0, no pulses.
REQ-029 keys[5] rises clean and is held -> one note_on, cn=5, note_valid=1; release -> one note_off, cn=16.
REQ-030 keys[5] glitches high for 8 cycles (2 ticks) then low -> no event; cn stays 16.
REQ-031 Hold keys[3], then add keys[9] -> cn 3 then 9 with 2 note_on pulses; release keys[9] -> cn=3 with note_on and no note_off; release keys[3] -> note_off, cn=16.
REQ-032 keys[2] and keys[7] press in the same tick -> cn=2 with a single note_on.
REQ-033 With NOTE_ENCODER_HOLD_EN defined: press then release keys[11] -> note_off, note_valid=0, cn stays 11; then pulse resetn low -> cn=16.

Source files
------------

// File: rtl/note_encoder.sv
// note_encoder: 16-key keyboard front end. Synchronises and debounces the raw
// key switches, then tracks the sounding note with last-note priority and
// emits registered note code plus attack/release pulses.
// Optional build macro NOTE_ENCODER_HOLD_EN: when defined, cn keeps the last
// note value after playing ends instead of returning to the idle code 16.
module note_encoder #(
  parameter int TICK_DIV = 50000,
  parameter int DEB_CNT  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] keys,
  output logic [4:0]  cn,
  output logic        note_valid,
  output logic        note_on,
  output logic        note_off
);

  localparam int          TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]  DEB_LIM   = 4'(DEB_CNT);
  localparam logic [4:0]  NO_NOTE   = 5'd16;

  typedef enum logic {IDLE, PLAYING} state_t;

  logic [15:0]   sync_p0;
  logic [15:0]   sync_p1;
  logic [TW-1:0] tick_q;
  logic          tick;
  logic [15:0]   stable_q;
  logic [15:0]   stable_nxt;
  logic [3:0]    cnt_q   [16];
  logic [3:0]    cnt_nxt [16];
  logic [15:0]   press;
  logic [15:0]   release_ev;
  state_t        state_q;
  state_t        state_nxt;
  logic [4:0]    cn_nxt;
  logic          valid_nxt;
  logic          on_nxt;
  logic          off_nxt;

  // Lowest set bit index of a key vector; 16 when the vector is empty.
  function automatic logic [4:0] lowest_key(input logic [15:0] v);
    logic [4:0] idx;
    idx = NO_NOTE;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Two-flop synchroniser on every raw key line.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= keys;
      sync_p1 <= sync_p0;
    end
  end

  // Free-running sample tick divider, tick asserted on its last count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q <= '0;
    end else if (tick) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  assign tick = (tick_q == TICK_LAST);

  // Per-key debounce: a key flips its stable level after DEB_CNT consecutive
  // disagreeing ticks; any agreeing tick restarts the count.
  always_comb begin
    stable_nxt = stable_q;
    for (int i = 0; i < 16; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (tick) begin
        if (sync_p1[i] != stable_q[i]) begin
          if (cnt_q[i] + 4'd1 == DEB_LIM) begin
            stable_nxt[i] = ~stable_q[i];
            cnt_nxt[i]    = 4'd0;
          end else begin
            cnt_nxt[i] = cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_nxt[i] = 4'd0;
        end
      end
    end
  end

  // Debounced key levels and their disagreement counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_q <= '0;
      cnt_q    <= '{default: 4'd0};
    end else begin
      stable_q <= stable_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  // Press/release events exist only in tick cycles since stable only moves then.
  assign press      = stable_nxt & ~stable_q;
  assign release_ev = stable_q & ~stable_nxt;

  // Note tracking: newest press wins; releasing the sounding note falls back
  // to the lowest still-held key, or ends playing when nothing is held.
  always_comb begin
    state_nxt = state_q;
    cn_nxt    = cn;
    valid_nxt = note_valid;
    on_nxt    = 1'b0;
    off_nxt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press != '0) begin
          state_nxt = PLAYING;
          cn_nxt    = lowest_key(press);
          valid_nxt = 1'b1;
          on_nxt    = 1'b1;
        end
      end
      PLAYING: begin
        if (press != '0) begin
          cn_nxt = lowest_key(press);
          on_nxt = 1'b1;
        end else if (release_ev[cn[3:0]]) begin
          if (stable_nxt != '0) begin
            cn_nxt = lowest_key(stable_nxt);
            on_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            off_nxt   = 1'b1;
`ifdef NOTE_ENCODER_HOLD_EN
            cn_nxt    = cn;
`else
            cn_nxt    = NO_NOTE;
`endif
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cn_nxt    = NO_NOTE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Registered FSM state and outputs, updated at the edge that ends the tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cn         <= NO_NOTE;
      note_valid <= 1'b0;
      note_on    <= 1'b0;
      note_off   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cn         <= cn_nxt;
      note_valid <= valid_nxt;
      note_on    <= on_nxt;
      note_off   <= off_nxt;
    end
  end

endmodule
